// File: rtl/cell_window_builder.sv
// Turns a raster pixel stream into 3x3 cell windows using two line buffers and a shift window.
// Defining CELL_WINDOW_FRAME_DONE_EN adds a frameDone pulse that marks the last cell of each frame.
module cell_window_builder #(
    parameter int IMG_W   = 640,
    parameter int IMG_H   = 480,
    parameter int PIXEL_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PIXEL_W-1:0]   pixelIn,
    input  logic                 pixelValid,
    output logic                 pixelReady,
    output logic [9*PIXEL_W-1:0] cellOut,
    output logic                 cellValid,
    input  logic                 cellReady
`ifdef CELL_WINDOW_FRAME_DONE_EN
    ,
    output logic                 frameDone
`endif
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [COL_W-1:0]     r_col;
    logic [ROW_W-1:0]     r_row;
    logic [PIXEL_W-1:0]   r_line1 [IMG_W];
    logic [PIXEL_W-1:0]   r_line2 [IMG_W];
    logic [PIXEL_W-1:0]   r_win   [9];
    logic [PIXEL_W-1:0]   w_winNext [9];
    logic [9*PIXEL_W-1:0] w_cellNext;
    logic [9*PIXEL_W-1:0] r_cellOut;
    logic                 r_cellValid;
    logic                 w_accept;
    logic                 w_lastCol;
    logic                 w_lastRow;
    logic                 w_cellDone;
    logic [PIXEL_W-1:0]   w_top;
    logic [PIXEL_W-1:0]   w_mid;

    assign pixelReady = (!r_cellValid || cellReady) && !rst;
    assign w_accept   = pixelValid && pixelReady;
    assign w_lastCol  = (r_col == COL_W'(IMG_W - 1));
    assign w_lastRow  = (r_row == ROW_W'(IMG_H - 1));
    assign w_cellDone = w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
    assign w_top      = r_line2[r_col];
    assign w_mid      = r_line1[r_col];
    assign cellOut    = r_cellOut;
    assign cellValid  = r_cellValid;

    // Window after this accept: every row shifts left, new right column comes from rows r-2, r-1, r.
    always_comb begin
        w_winNext[0] = r_win[1];
        w_winNext[1] = r_win[2];
        w_winNext[2] = w_top;
        w_winNext[3] = r_win[4];
        w_winNext[4] = r_win[5];
        w_winNext[5] = w_mid;
        w_winNext[6] = r_win[7];
        w_winNext[7] = r_win[8];
        w_winNext[8] = pixelIn;
    end

    always_comb begin
        w_cellNext = '0;
        for (int k = 0; k < 9; k++) begin
            w_cellNext[k*PIXEL_W +: PIXEL_W] = w_winNext[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_lastCol) begin
                r_col <= '0;
                r_row <= w_lastRow ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Line buffers are never cleared: rows 0 and 1 of a fresh frame overwrite them before any cell reads them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_line2[r_col] <= w_mid;
            r_line1[r_col] <= pixelIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= w_winNext[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cellOut   <= '0;
            r_cellValid <= 1'b0;
        end else if (w_cellDone) begin
            r_cellOut   <= w_cellNext;
            r_cellValid <= 1'b1;
        end else if (cellReady) begin
            r_cellValid <= 1'b0;
        end
    end

`ifdef CELL_WINDOW_FRAME_DONE_EN
    logic r_frameDone;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= w_cellDone && w_lastCol && w_lastRow;
        end
    end

    assign frameDone = r_frameDone;
`endif

endmodule

// File: doc/cell_window_builder.md
CELL_WINDOW_BUILDER -- requirements
Module: cell_window_builder

Interface
REQ-001 Parameter: IMG_W, default 640, pixels per image row (SHALL be >= 3).
REQ-002 Parameter: IMG_H, default 480, rows per frame (SHALL be >= 3).
REQ-003 Parameter: PIXEL_W, default 24, bits per pixel, matching the processing package pixel type.
REQ-004 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: pixelIn  input  PIXEL_W  raster-order input pixel.
REQ-007 Port: pixelValid  input  1  pixelIn valid.
REQ-008 Port: pixelReady  output  1  block accepts pixelIn this cycle.
REQ-009 Port: cellOut  output  9*PIXEL_W  3x3 window, packed as a cell; element 0 = top-left, raster order, element 4 = center pixel.
REQ-010 Port: cellValid  output  1  cellOut holds a complete window.
REQ-011 Port: cellReady  input  1  downstream cell processor consumes cellOut this cycle.

Function
REQ-012 An input pixel SHALL be accepted only on cycles where pixelValid && pixelReady.
REQ-013 pixelReady SHALL equal (!cellValid || cellReady) && !rst, driven combinationally.
REQ-014 The block SHALL keep col (0..IMG_W-1) and row (0..IMG_H-1) counters for the next pixel to be accepted; each accept increments col, and col wraps to 0 with row incremented.
REQ-015 Accepting pixel (row IMG_H-1, col IMG_W-1) SHALL reset both counters to 0 so the next pixel starts a new frame.
REQ-016 The block SHALL hold two IMG_W-deep line buffers (rows r-1 and r-2) plus a 3x3 shift window; each accept shifts the window one column left, inserting {lineBuf2[col], lineBuf1[col], pixelIn} as the new right column, top to bottom.
REQ-017 Line buffers SHALL update on accept only: lineBuf2[col] <= lineBuf1[col], lineBuf1[col] <= pixelIn.
REQ-018 An accept at row >= 2 and col >= 2 SHALL load the window into cellOut and set cellValid on the next edge; its center is the pixel at (row-1, col-1).
REQ-019 Accepts at row < 2 or col < 2 SHALL update state but SHALL NOT produce a cell; border pixels are never centers.
REQ-020 A frame SHALL yield exactly (IMG_W-2)*(IMG_H-2) cells, with no mixing of rows across frames.
REQ-021 Latency: cellValid SHALL rise one cycle after the accept that completes a window.
REQ-022 cellValid && !cellReady SHALL hold cellOut and cellValid stable with no accepts (backpressure).
REQ-023 cellValid && cellReady with no new window SHALL clear cellValid on the next edge; simultaneous consume and new window SHALL load the new cell with cellValid staying 1.
REQ-024 pixelValid low SHALL freeze all counters, buffers and the window.

Reset
REQ-025 On a clk edge with rst high: cellValid=0, cellOut=0, col=0, row=0; window registers cleared; line buffer contents need not be cleared.
REQ-026 Reset mid-frame SHALL discard the partial frame; the first pixel accepted after rst falls is (0,0) of a new frame.

Configuration
REQ-027 Macro CELL_WINDOW_FRAME_DONE_EN defined: an extra output frameDone (1 bit, reset 0) SHALL pulse high for exactly one cycle, coincident with cellValid rising for the last cell of a frame.
REQ-028 Macro CELL_WINDOW_FRAME_DONE_EN undefined: frameDone port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-029 IMG_W=IMG_H=4, pixels 0..15, pixelValid always 1, cellReady 1 -> first cellValid one cycle after pixel 10 is accepted, cellOut={0,1,2,4,5,6,8,9,10}, center 5.
REQ-030 Same stimulus -> exactly 4 cells per frame, centers 5,6,9,10 in that order.
REQ-031 cellReady held 0 for 3 cycles while cellValid=1 -> cellOut unchanged, pixelReady=0 for those 3 cycles, no pixel lost; stream resumes on cellReady=1.
REQ-032 rst pulsed after pixel 6 of frame 1, then pixels 0..15 sent -> first cell center 5, no cell built from pre-reset data.
REQ-033 Two back-to-back frames of pixels 0..15 -> 8 cells total; second frame's first cell is {0,1,2,4,5,6,8,9,10}; with CELL_WINDOW_FRAME_DONE_EN, frameDone pulses once, with center-10 cell of each frame.
REQ-034 pixelValid toggled 1/0 every cycle -> same cell sequence as REQ-030, each cell one cycle after its completing accept.
